// File: rtl/cache_types_pkg.sv
// Shared types for the L1 cache sequencing FSM.
// Holds the controller state encoding and the datapath mux select encodings.
// Imported by cache_control and by anything that decodes its select outputs.
package cache_types_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } cache_state_t;

  // data array write source
  localparam logic DSEL_CPU  = 1'b0;
  localparam logic DSEL_PMEM = 1'b1;

  // physical memory address source
  localparam logic PADDR_CPU    = 1'b0;
  localparam logic PADDR_VICTIM = 1'b1;

endpackage

// File: rtl/cache_control.sv
// Sequencing FSM for a 2-way set-associative L1 cache: hits, writeback of dirty victims, line fills.
// Latency: hit completes the same cycle; miss costs the pmem transfer cycles plus one re-evaluation cycle.
// Backpressure: the CPU holds its request until mem_resp; pmem strobes are held until pmem_resp.
module cache_control
  import cache_types_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mem_read,
  input  logic mem_write,
  output logic mem_resp,
  input  logic hit,
  input  logic hit_way,
  input  logic dirty,
  input  logic update_way,
  output logic pmem_read,
  output logic pmem_write,
  input  logic pmem_resp,
  output logic way_sel,
  output logic load_data,
  output logic data_sel,
  output logic load_tag,
  output logic load_valid,
  output logic load_dirty,
  output logic dirty_in,
  output logic load_lru,
  output logic lru_in,
  output logic pmem_addr_sel
);

  cache_state_t state;
  cache_state_t next_state;
  logic         victim_way;
  logic         req;
  logic         miss_start;

  assign req        = mem_read | mem_write;
  assign miss_start = (state == IDLE) && req && !hit;

  // State register; a reset mid-miss abandons the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Victim way is frozen when the miss starts so later update_way changes cannot redirect the fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      victim_way <= 1'b0;
    end else if (miss_start) begin
      victim_way <= update_way;
    end
  end

  // Next-state: dirty misses write back before fetching; a fill returns to IDLE to re-evaluate as a hit.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (miss_start) next_state = dirty ? WRITEBACK : FETCH;
      WRITEBACK: if (pmem_resp)  next_state = FETCH;
      FETCH:     if (pmem_resp)  next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output decode; the hit path also performs the LRU update and write merge after a fill.
  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    way_sel       = 1'b0;
    load_data     = 1'b0;
    data_sel      = DSEL_CPU;
    load_tag      = 1'b0;
    load_valid    = 1'b0;
    load_dirty    = 1'b0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    pmem_addr_sel = PADDR_CPU;
    case (state)
      IDLE: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          way_sel  = hit_way;
          load_lru = 1'b1;
          lru_in   = ~hit_way;
          // read+write together is treated as a write
          if (mem_write) begin
            load_data  = 1'b1;
            data_sel   = DSEL_CPU;
            load_dirty = 1'b1;
            dirty_in   = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = PADDR_VICTIM;
        way_sel       = victim_way;
      end
      FETCH: begin
        pmem_read     = 1'b1;
        pmem_addr_sel = PADDR_CPU;
        way_sel       = victim_way;
        if (pmem_resp) begin
          load_data  = 1'b1;
          data_sel   = DSEL_PMEM;
          load_tag   = 1'b1;
          load_valid = 1'b1;
          load_dirty = 1'b1;
          dirty_in   = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
